// File: rtl/conv_window_gen_if.sv
// Channel-memory read port and window handshake of conv_window_gen.
// master = surrounding system, slave = the window generator.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    start;
  logic [DATA_WIDTH-1:0]   mem_data;
  logic                    mem_oe;
  logic                    mem_rdinc;
  logic                    mem_rptclr;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    win_valid;
  logic                    win_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, mem_data, win_ready,
    input  mem_oe, mem_rdinc, mem_rptclr,
    input  win_data, win_valid, busy, done
  );

  modport slave (
    input  start, mem_data, win_ready,
    output mem_oe, mem_rdinc, mem_rptclr,
    output win_data, win_valid, busy, done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster reader of one channel plus 3x3 stride-1 unpadded window
// assembler feeding the MAC array over a valid/ready handshake.
module conv_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input logic             CONV_WINDOW_GEN_Clk,
  input logic             CONV_WINDOW_GEN_Reset_n,
  conv_window_gen_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX + 1);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H + 1);
  localparam logic [AW-1:0] LAST = AW'(NPIX);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  state_t                  state, nxt;
  logic [AW-1:0]           rd_cnt;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic [DATA_WIDTH-1:0]   line1 [IMG_W];
  logic [DATA_WIDTH-1:0]   line2 [IMG_W];
  logic [DATA_WIDTH-1:0]   win [9];
  logic [9*DATA_WIDTH-1:0] wdata;
  logic                    win_valid;
  logic                    done;
  logic                    drain_ok;
  logic                    oe;
  logic                    emit;

  assign drain_ok = !win_valid || bus.win_ready;
  assign oe = (state == STREAM) && (rd_cnt < LAST) && drain_ok;
  // col < 2 pixels never emit, so no window spans a row wrap
  assign emit = oe && (row >= RW'(2)) && (col >= CW'(2));

  assign bus.mem_oe     = oe;
  assign bus.mem_rdinc  = oe;
  assign bus.mem_rptclr = (state != CLEAR);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;
  assign bus.win_valid  = win_valid;
  assign bus.win_data   = wdata;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < 9; i++)
      wdata[i*DATA_WIDTH +: DATA_WIDTH] = win[i];
  end

  always_ff @(posedge CONV_WINDOW_GEN_Clk or negedge CONV_WINDOW_GEN_Reset_n) begin
    if (!CONV_WINDOW_GEN_Reset_n) state <= IDLE;
    else                          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = CLEAR;
      CLEAR:   nxt = STREAM;
      STREAM:  if (rd_cnt == LAST) nxt = DRAIN;
      DRAIN:   if (drain_ok) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CONV_WINDOW_GEN_Clk or negedge CONV_WINDOW_GEN_Reset_n) begin
    if (!CONV_WINDOW_GEN_Reset_n) begin
      rd_cnt    <= '0;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        line1[i] <= '0;
        line2[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      done <= (state == DRAIN) && drain_ok;
      if (state == CLEAR) begin
        rd_cnt <= '0;
        col    <= '0;
        row    <= '0;
      end else if (oe) begin
        if (rd_cnt != LAST) rd_cnt <= rd_cnt + 1'b1;
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        line1[0] <= bus.mem_data;
        line2[0] <= line1[IMG_W-1];
        for (int i = 1; i < IMG_W; i++) begin
          line1[i] <= line1[i-1];
          line2[i] <= line2[i-1];
        end
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= line2[IMG_W-1];
        win[5] <= line1[IMG_W-1];
        win[8] <= bus.mem_data;
      end
      if (emit)               win_valid <= 1'b1;
      else if (bus.win_ready) win_valid <= 1'b0;
    end
  end
endmodule
